// File: rtl/uart_tx_multi.sv
// UART transmitter with an input FIFO and run-time frame configuration (length, parity, stop bits, baud).
// Latency: a word written into an empty FIFO while IDLE drives the start bit after the second edge.
// Backpressure: FULL flags a full FIFO; a write while FULL is silently dropped.
module uart_tx_multi #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PRESCALE_W = 8
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [DATA_WIDTH-1:0]           P_DATA,
  input  logic                            DATA_VALID,
  input  logic                            PAR_EN,
  input  logic                            PAR_TYP,
  input  logic                            STOP2,
  input  logic [$clog2(DATA_WIDTH+1)-1:0] DATA_LEN,
  input  logic [PRESCALE_W-1:0]           PRESCALE,
  output logic                            TX_OUT,
  output logic                            BUSY,
  output logic                            FULL,
  output logic                            EMPTY
);
  localparam int LW = $clog2(DATA_WIDTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // FIFO storage and bookkeeping
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  full_q, empty_q;
  logic                  wr_en, pop;

  // Frame engine state
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [LW-1:0]         len_q, len_d, bit_q, bit_d;
  logic [PRESCALE_W-1:0] prd_q, prd_d, baud_q, baud_d;
  logic                  par_en_q, par_en_d, par_typ_q, par_typ_d, stop2_q, stop2_d;
  logic                  stop_q, stop_d;
  logic                  tx_q, tx_d;
  logic                  bit_end, par_bit;
  logic [DATA_WIDTH-1:0] shifted, mask;

  // Out-of-range lengths are pulled back into 5..DATA_WIDTH
  function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
    if (l < LW'(5)) return LW'(5);
    if (l > LW'(DATA_WIDTH)) return LW'(DATA_WIDTH);
    return l;
  endfunction

  assign wr_en   = DATA_VALID & ~full_q;
  assign cnt_d   = cnt_q + CW'(wr_en) - CW'(pop);
  assign bit_end = (baud_q == prd_q - 1'b1);
  assign mask    = ~({DATA_WIDTH{1'b1}} << len_q);
  assign par_bit = (^(data_q & mask)) ^ par_typ_q;

  // FIFO payload; no reset needed since occupancy gates every read
  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_ptr_q] <= P_DATA;
  end

  // FIFO pointers, occupancy and registered full/empty flags
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CW'(FIFO_DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  // Next-state, counters, pop/config latch and next line value
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    len_d     = len_q;
    prd_d     = prd_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    stop2_d   = stop2_q;
    bit_d     = bit_q;
    stop_d    = stop_q;
    baud_d    = bit_end ? '0 : baud_q + 1'b1;
    pop       = 1'b0;
    tx_d      = 1'b1;
    shifted   = '0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        pop    = ~empty_q;
      end
      START: if (bit_end) begin
        state_d = DATA;
        bit_d   = '0;
      end
      DATA: if (bit_end) begin
        if (bit_q == len_q - 1'b1) begin
          state_d = par_en_q ? PARITY : STOP;
          stop_d  = 1'b0;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      PARITY: if (bit_end) begin
        state_d = STOP;
        stop_d  = 1'b0;
      end
      STOP: if (bit_end) begin
        if (stop_q == stop2_q) begin
          if (!empty_q) pop = 1'b1;
          else          state_d = IDLE;
        end else begin
          stop_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A pop starts a new frame with the configuration present at that edge
    if (pop) begin
      state_d   = START;
      data_d    = mem_q[rd_ptr_q];
      len_d     = clamp_len(DATA_LEN);
      prd_d     = (PRESCALE == '0) ? PRESCALE_W'(1) : PRESCALE;
      par_en_d  = PAR_EN;
      par_typ_d = PAR_TYP;
      stop2_d   = STOP2;
      baud_d    = '0;
      bit_d     = '0;
    end
    case (state_d)
      START:   tx_d = 1'b0;
      DATA: begin
        shifted = data_d >> bit_d;
        tx_d    = shifted[0];
      end
      PARITY:  tx_d = par_bit;
      default: tx_d = 1'b1;
    endcase
  end

  // Frame engine registers; reset aborts any frame and idles the line
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      data_q    <= '0;
      len_q     <= LW'(DATA_WIDTH);
      prd_q     <= PRESCALE_W'(1);
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      stop2_q   <= 1'b0;
      bit_q     <= '0;
      stop_q    <= 1'b0;
      baud_q    <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      len_q     <= len_d;
      prd_q     <= prd_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      stop2_q   <= stop2_d;
      bit_q     <= bit_d;
      stop_q    <= stop_d;
      baud_q    <= baud_d;
      tx_q      <= tx_d;
    end
  end

  assign TX_OUT = tx_q;
  assign BUSY   = (state_q != IDLE);
  assign FULL   = full_q;
  assign EMPTY  = empty_q;

endmodule

// File: tb/tb_uart_tx_multi.sv
// Scoreboard bench for uart_tx_multi: expected frames are queued at write time
// and compared bit-by-bit, cycle-by-cycle against the serial line.
module tb_uart_tx_multi;
  logic       CLK, RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID, PAR_EN, PAR_TYP, STOP2;
  logic [3:0] DATA_LEN;
  logic [7:0] PRESCALE;
  logic       TX_OUT, BUSY, FULL, EMPTY;

  uart_tx_multi #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .PRESCALE_W(8)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2), .DATA_LEN(DATA_LEN),
    .PRESCALE(PRESCALE), .TX_OUT(TX_OUT), .BUSY(BUSY), .FULL(FULL), .EMPTY(EMPTY)
  );

  typedef struct {
    int          id;
    int          nbits;
    int          p;
    logic [15:0] bits;
  } frame_t;

  frame_t exp_q[$];
  int     n_tests = 0;
  int     n_fail  = 0;
  int     next_id = 0;
  int     busy_cnt = 0;
  int     last_run = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Build the expected line sequence from the configuration the bench drives
  function automatic frame_t make_frame(input logic [7:0] d);
    frame_t f;
    int l, idx;
    logic par;
    l = int'(DATA_LEN);
    if (l < 5) l = 5;
    if (l > 8) l = 8;
    f.id    = next_id;
    f.p     = (PRESCALE == 0) ? 1 : int'(PRESCALE);
    f.bits  = '1;
    f.bits[0] = 1'b0;
    idx = 1;
    par = PAR_TYP;
    for (int i = 0; i < l; i++) begin
      f.bits[idx] = d[i];
      par = par ^ d[i];
      idx++;
    end
    if (PAR_EN) begin
      f.bits[idx] = par;
      idx++;
    end
    idx = idx + (STOP2 ? 2 : 1);
    f.nbits = idx;
    return f;
  endfunction

  task automatic expect_word(input logic [7:0] d);
    exp_q.push_back(make_frame(d));
    next_id++;
  endtask

  task automatic send(input logic [7:0] d);
    P_DATA     = d;
    DATA_VALID = 1'b1;
    step();
    DATA_VALID = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while ((BUSY || !EMPTY || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check({tag, "_drain"}, int'(n < budget), 1);
    step();
  endtask

  // Length of each uninterrupted BUSY run, in cycles
  always @(negedge CLK) begin
    if (BUSY === 1'b1) busy_cnt++;
    else if (busy_cnt != 0) begin
      last_run = busy_cnt;
      busy_cnt = 0;
    end
  end

  // Line monitor: a low level outside a frame is a start bit; compare every cycle of every bit
  initial begin : monitor
    frame_t f;
    int     bad;
    bit     aborted;
    forever begin
      @(negedge CLK);
      if (RST === 1'b1 && TX_OUT === 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
        end else begin
          f = exp_q.pop_front();
          aborted = 1'b0;
          for (int b = 0; b < f.nbits && !aborted; b++) begin
            bad = 0;
            for (int c = 0; c < f.p; c++) begin
              if (b != 0 || c != 0) @(negedge CLK);
              if (RST !== 1'b1) begin
                aborted = 1'b1;
                break;
              end
              if (TX_OUT !== f.bits[b]) bad++;
            end
            if (!aborted) check($sformatf("frame%0d_bit%0d_badcycles", f.id, b), bad, 0);
          end
        end
      end
    end
  end

  initial begin : main
    int bad;
    RST = 1'b0; P_DATA = '0; DATA_VALID = 1'b0;
    PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0; DATA_LEN = 4'd8; PRESCALE = 8'd1;
    repeat (3) step();
    check("rst_tx", TX_OUT, 1);
    check("rst_busy", BUSY, 0);
    check("rst_full", FULL, 0);
    check("rst_empty", EMPTY, 1);
    RST = 1'b1;
    repeat (2) step();

    // 1: 8N1 at one cycle per bit, with exact start latency
    expect_word(8'hA5);
    send(8'hA5);
    check("t1_empty_after_write", EMPTY, 0);
    check("t1_tx_before_pop", TX_OUT, 1);
    step();
    check("t1_tx_start", TX_OUT, 0);
    check("t1_busy_start", BUSY, 1);
    wait_done("t1", 100);
    check("t1_busy_len", last_run, 10);

    // 2: 7 bits, odd parity, two stop bits, 4 cycles per bit
    DATA_LEN = 4'd7; PAR_EN = 1'b1; PAR_TYP = 1'b1; STOP2 = 1'b1; PRESCALE = 8'd4;
    expect_word(8'h55);
    send(8'h55);
    wait_done("t2", 200);
    check("t2_busy_len", last_run, 44);

    // 3: overfill the FIFO; the sixth word is dropped, the rest go back-to-back
    DATA_LEN = 4'd8; PAR_EN = 1'b0; STOP2 = 1'b0; PRESCALE = 8'd8;
    for (int i = 1; i <= 6; i++) begin
      if (i <= 5) expect_word(8'(i));
      send(8'(i));
      check($sformatf("t3_full_after_w%0d", i), FULL, int'(i >= 5));
    end
    wait_done("t3", 1000);
    check("t3_busy_len", last_run, 400);
    check("t3_empty_end", EMPTY, 1);
    check("t3_busy_end", BUSY, 0);

    // 4: config changed mid-frame only affects the next frame
    DATA_LEN = 4'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0; PRESCALE = 8'd3;
    expect_word(8'h3C);
    send(8'h3C);
    repeat (10) step();
    DATA_LEN = 4'd6; PAR_TYP = 1'b1; PRESCALE = 8'd2;
    expect_word(8'hC7);
    send(8'hC7);
    wait_done("t4", 300);
    check("t4_busy_len", last_run, 51);

    // 5: length clamping and PRESCALE=0
    PAR_EN = 1'b0; PRESCALE = 8'd0; DATA_LEN = 4'd3;
    expect_word(8'hFA);
    send(8'hFA);
    wait_done("t5a", 100);
    check("t5a_busy_len", last_run, 7);
    DATA_LEN = 4'd15;
    expect_word(8'h96);
    send(8'h96);
    wait_done("t5b", 100);
    check("t5b_busy_len", last_run, 10);

    // 6: reset during DATA with two words queued
    DATA_LEN = 4'd8; PRESCALE = 8'd4;
    expect_word(8'h11);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    repeat (8) step();
    RST = 1'b0;
    #1;
    check("t6_tx_in_rst", TX_OUT, 1);
    check("t6_busy_in_rst", BUSY, 0);
    check("t6_empty_in_rst", EMPTY, 1);
    check("t6_full_in_rst", FULL, 0);
    exp_q.delete();
    repeat (2) step();
    RST = 1'b1;
    bad = 0;
    repeat (30) begin
      step();
      if (TX_OUT !== 1'b1 || BUSY !== 1'b0) bad++;
    end
    check("t6_idle_after_rst", bad, 0);
    expect_word(8'h5A);
    send(8'h5A);
    wait_done("t6", 200);
    check("t6_busy_len", last_run, 40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
